// File: rtl/pwm_channel.sv
// Single PWM channel driven by an external counter. Compare values and mode are
// double-buffered and only take effect on a period boundary (or while disabled).
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_en,
  input  logic             upnotdown,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] count_val,
  input  logic [1:0]       functions,
  input  logic [WIDTH-1:0] compare1,
  input  logic [WIDTH-1:0] compare2,
  output logic             pwm_out,
  output logic             period_done
);

  localparam logic [1:0] FN_LEFT  = 2'b00;
  localparam logic [1:0] FN_RIGHT = 2'b01;
  localparam logic [1:0] FN_RANGE = 2'b10;

  logic [WIDTH-1:0] prev_count;
  logic [WIDTH-1:0] act_cmp1;
  logic [WIDTH-1:0] act_cmp2;
  logic [1:0]       act_fn;

  logic             changed;
  logic             boundary;
  logic [WIDTH-1:0] eff_cmp1;
  logic [WIDTH-1:0] eff_cmp2;
  logic [1:0]       eff_fn;
  logic             pwm_next;

  // A held count (prescaler) must not re-trigger the boundary, hence the change test.
  always_comb begin
    changed  = (count_val != prev_count);
    boundary = pwm_en & changed &
               (upnotdown ? (count_val == '0) : (count_val == period));
  end

  // On the boundary cycle the shadow values are used directly, so a write
  // landing on that exact cycle is not delayed by a whole period.
  always_comb begin
    eff_cmp1 = act_cmp1;
    eff_cmp2 = act_cmp2;
    eff_fn   = act_fn;
    if (boundary) begin
      eff_cmp1 = compare1;
      eff_cmp2 = compare2;
      eff_fn   = functions;
    end
  end

  always_comb begin
    pwm_next = 1'b0;
    if (pwm_en) begin
      case (eff_fn)
        FN_LEFT:  pwm_next = (count_val < eff_cmp1);
        FN_RIGHT: pwm_next = (count_val >= eff_cmp1);
        FN_RANGE: pwm_next = (count_val >= eff_cmp1) && (count_val < eff_cmp2);
        default:  pwm_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_count <= '0;
      act_cmp1   <= '0;
      act_cmp2   <= '0;
      act_fn     <= FN_LEFT;
    end else begin
      prev_count <= count_val;
      // Transparent while disabled so re-enabling starts from fresh values.
      if (!pwm_en || boundary) begin
        act_cmp1 <= compare1;
        act_cmp2 <= compare2;
        act_fn   <= functions;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= pwm_next;
      period_done <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_channel.sv
// Bench for pwm_channel: a behavioural counter plus a reference model feed an
// expected queue; directed scenarios also check pulse widths per period.
module tb_pwm_channel;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         pwm_en;
  logic         upnotdown;
  logic [W-1:0] period;
  logic [W-1:0] count_val;
  logic [1:0]   functions;
  logic [W-1:0] compare1;
  logic [W-1:0] compare2;
  logic         pwm_out;
  logic         period_done;

  pwm_channel #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .upnotdown(upnotdown),
    .period(period), .count_val(count_val), .functions(functions),
    .compare1(compare1), .compare2(compare2),
    .pwm_out(pwm_out), .period_done(period_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // behavioural counter
  logic [W-1:0] cnt;
  int presc;
  int pc;

  // reference model state: last seen count and the latched settings
  logic [W-1:0] m_prev;
  logic [1:0]   m_fn;
  logic [W-1:0] m_c1;
  logic [W-1:0] m_c2;

  // per-period measurement
  int hi_run;
  int last_width;
  int pd_cnt;
  int hi_cnt;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic level(input logic [1:0] f, input logic [W-1:0] c1,
                                 input logic [W-1:0] c2, input logic [W-1:0] v);
    case (f)
      2'b00:   return v < c1;
      2'b01:   return v >= c1;
      2'b10:   return (v >= c1) && (v < c2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_prev = '0; m_fn = 2'b00; m_c1 = '0; m_c2 = '0;
    cnt = '0; pc = 0; count_val = '0;
  endtask

  // One clock: drive at negedge, predict, then check just after the posedge.
  task automatic step();
    logic ch, bnd, p;
    logic [1:0] f;
    logic [W-1:0] c1, c2;
    logic [1:0] e;
    @(negedge clk);
    if (pc >= presc) begin
      pc = 0;
      if (upnotdown) cnt = (cnt >= period) ? '0 : cnt + 1'b1;
      else           cnt = (cnt == '0) ? period : cnt - 1'b1;
    end else begin
      pc++;
    end
    count_val = cnt;
    ch  = (cnt != m_prev);
    bnd = pwm_en && ch && (upnotdown ? (cnt == '0) : (cnt == period));
    f  = bnd ? functions : m_fn;
    c1 = bnd ? compare1  : m_c1;
    c2 = bnd ? compare2  : m_c2;
    p  = pwm_en ? level(f, c1, c2, cnt) : 1'b0;
    exp_q.push_back({p, bnd});
    m_prev = cnt;
    if (!pwm_en || bnd) begin
      m_fn = functions; m_c1 = compare1; m_c2 = compare2;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("pwm_out", int'(pwm_out), int'(e[1]));
    check_eq("period_done", int'(period_done), int'(e[0]));
    hi_cnt += int'(pwm_out);
    if (period_done) begin
      pd_cnt++;
      last_width = hi_run;
      hi_run = int'(pwm_out);
    end else begin
      hi_run += int'(pwm_out);
    end
  endtask

  task automatic run_periods(input int n);
    int target;
    int budget;
    target = pd_cnt + n;
    budget = 3000;
    while (pd_cnt < target && budget > 0) begin
      step();
      budget--;
    end
    if (pd_cnt < target) check_eq("period_timeout", pd_cnt, target);
  endtask

  task automatic setup(input logic up, input logic [W-1:0] per, input int ps,
                       input logic [1:0] f, input logic [W-1:0] c1, input logic [W-1:0] c2);
    upnotdown = up; period = per; presc = ps;
    functions = f; compare1 = c1; compare2 = c2;
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_pwm_out", int'(pwm_out), 0);
    check_eq("rst_period_done", int'(period_done), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    int pd0, hi0;
    rst_n = 1'b0; pwm_en = 1'b0;
    hi_run = 0; last_width = 0; pd_cnt = 0; hi_cnt = 0;
    setup(1'b1, 16'd10, 0, 2'b00, 16'd0, 16'd0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_pwm_out", int'(pwm_out), 0);
    check_eq("reset_period_done", int'(period_done), 0);
    rst_n = 1'b1;

    // Up, period 10, left, compare1=4
    pwm_en = 1'b1;
    setup(1'b1, 16'd10, 0, 2'b00, 16'd4, 16'd0);
    run_periods(3);
    check_eq("left4_width", last_width, 4);

    // Shadow write mid-period: current period unchanged, next one uses 7
    budget = 50;
    while (count_val != 16'd5 && budget > 0) begin step(); budget--; end
    check_eq("reach_count5", int'(count_val), 5);
    compare1 = 16'd7;
    run_periods(1);
    check_eq("left_keep4", last_width, 4);
    run_periods(1);
    check_eq("left_new7", last_width, 7);

    // Prescale 2: each count lasts 3 clocks
    setup(1'b1, 16'd10, 2, 2'b00, 16'd4, 16'd0);
    run_periods(3);
    check_eq("presc_width", last_width, 12);

    // Range 3..7, then inverted range gives a flat zero
    setup(1'b1, 16'd10, 0, 2'b10, 16'd3, 16'd8);
    run_periods(3);
    check_eq("range_width", last_width, 5);
    compare1 = 16'd8; compare2 = 16'd3;
    run_periods(3);
    check_eq("range_inv_width", last_width, 0);

    // Down, period 5, right mode compare1=2 -> counts 5,4,3,2 high
    setup(1'b0, 16'd5, 0, 2'b01, 16'd2, 16'd0);
    run_periods(3);
    check_eq("down_right_width", last_width, 4);

    // Reset while output is high
    setup(1'b1, 16'd10, 0, 2'b00, 16'd6, 16'd0);
    run_periods(2);
    budget = 50;
    while (pwm_out !== 1'b1 && budget > 0) begin step(); budget--; end
    check_eq("pre_reset_high", int'(pwm_out), 1);
    async_reset();
    run_periods(3);
    check_eq("post_reset_width", last_width, 6);

    // Disabled channel: no output, no period pulses
    pwm_en = 1'b0;
    pd0 = pd_cnt; hi0 = hi_cnt;
    repeat (30) step();
    check_eq("dis_pd_count", pd_cnt - pd0, 0);
    check_eq("dis_hi_count", hi_cnt - hi0, 0);
    pwm_en = 1'b1;

    // Reserved mode
    setup(1'b1, 16'd10, 0, 2'b11, 16'd5, 16'd9);
    run_periods(2);
    hi0 = hi_cnt;
    run_periods(2);
    check_eq("mode11_hi_count", hi_cnt - hi0, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        functions = 2'($urandom_range(0, 3));
        compare1  = W'($urandom_range(0, int'(period) + 2));
        compare2  = W'($urandom_range(0, int'(period) + 2));
      end
      if ($urandom_range(0, 60) == 0) pwm_en = ~pwm_en;
      if ($urandom_range(0, 150) == 0) upnotdown = ~upnotdown;
      if ($urandom_range(0, 150) == 0) period = W'($urandom_range(2, 20));
      if ($urandom_range(0, 200) == 0) presc = $urandom_range(0, 3);
      if ($urandom_range(0, 400) == 0) async_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
